cu_mc: RTL and testbench

- Parametrised multicycle control unit for the mycpu datapath.
- It decodes the instruction register and drives the datapath microoperation fields: PC select, IR load, register selects, bus/ALU muxes, write enables and I/O select.
- Compared with the previous CU, it adds:
  - generic register-address width
  - a memory/IO ready handshake with wait states
  - a micro-sequenced multi-bit shift loop
  - halt/resume
  - illegal-opcode reporting
- Sits between the instruction register / status flags and the datapath, register file and memory/IO.

---
 rtl/mycpu_pkg.sv | 63 ++++++
 rtl/cu_dec.sv | 37 +++
 rtl/cu_mc.sv | 176 +++++++++++++++++
 tb/tb_cu_mc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and constants for the mycpu multicycle control unit.
package mycpu_pkg;

    typedef enum logic [2:0] {
        RST = 3'd0,
        INF = 3'd1,
        EX0 = 3'd2,
        EXS = 3'd3,
        HLT = 3'd4
    } cu_mc_state_t;

    // Opcodes; the low nibble doubles as the ALU/shifter function select.
    typedef enum logic [6:0] {
        OP_MOVA = 7'b0000000,
        OP_INC  = 7'b0000001,
        OP_ADD  = 7'b0000010,
        OP_SUB  = 7'b0000101,
        OP_DEC  = 7'b0000110,
        OP_AND  = 7'b0001000,
        OP_OR   = 7'b0001001,
        OP_XOR  = 7'b0001010,
        OP_NOT  = 7'b0001011,
        OP_MOVB = 7'b0001100,
        OP_SHR  = 7'b0001101,
        OP_SHL  = 7'b0001110,
        OP_SRM  = 7'b0011101,
        OP_SLM  = 7'b0011110,
        OP_LD   = 7'b0010000,
        OP_IOR  = 7'b0010001,
        OP_ST   = 7'b0100000,
        OP_IOW  = 7'b0100001,
        OP_LDI  = 7'b1001100,
        OP_ADI  = 7'b1000010,
        OP_BRZ  = 7'b1100000,
        OP_BRN  = 7'b1100001,
        OP_JMP  = 7'b1110000,
        OP_HAL  = 7'b1110111,
        OP_XXL  = 7'b1111111
    } opcode_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [1:0] MD_ALU = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_IO  = 2'b10;

    // Instruction class flags produced by the opcode decoder.
    typedef struct packed {
        logic alu;
        logic imm;
        logic mem;
        logic io;
        logic load;
        logic br;
        logic shiftm;
        logic halt;
        logic illegal;
    } cu_dec_t;

endpackage

// File: rtl/cu_dec.sv
// Combinational opcode classifier for the multicycle control unit.
module cu_dec
    import mycpu_pkg::*;
(
    input  logic [6:0] opc,
    output cu_dec_t    dec_c
);

    // Map each opcode to its class; anything unlisted is illegal.
    always_comb begin
        dec_c = '0;
        case (opc)
            OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL: dec_c.alu = 1'b1;
            OP_LDI, OP_ADI: begin
                dec_c.alu = 1'b1;
                dec_c.imm = 1'b1;
            end
            OP_LD: begin
                dec_c.mem  = 1'b1;
                dec_c.load = 1'b1;
            end
            OP_ST: dec_c.mem = 1'b1;
            OP_IOR: begin
                dec_c.io   = 1'b1;
                dec_c.load = 1'b1;
            end
            OP_IOW: dec_c.io = 1'b1;
            OP_BRZ, OP_BRN, OP_JMP: dec_c.br = 1'b1;
            OP_SRM, OP_SLM: dec_c.shiftm = 1'b1;
            OP_HAL: dec_c.halt = 1'b1;
            OP_XXL: ;
            default: dec_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_mc.sv
// Multicycle control unit: fetch/execute sequencing, memory/IO wait states,
// micro-sequenced multi-bit shifts, halt/resume and illegal-opcode reporting.
module cu_mc
    import mycpu_pkg::*;
#(
    parameter int unsigned RA_W  = 3,
    parameter int unsigned OPC_W = 7,
    localparam int unsigned INS_W = OPC_W + 3 * RA_W,
    localparam int unsigned RS_W  = 3 * (RA_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins_in,
    input  logic             z_in,
    input  logic             n_in,
    input  logic             rdy_in,
    input  logic             run_in,
    output logic             il_out,
    output logic [1:0]       ps_out,
    output logic             rw_out,
    output logic [RS_W-1:0]  rs_out,
    output logic             mm_out,
    output logic [1:0]       md_out,
    output logic             mb_out,
    output logic [3:0]       fs_out,
    output logic             wen_out,
    output logic             iom_out,
    output logic             req_out,
    output logic             halted_out,
    output logic             illegal_out
);

    localparam int unsigned AW = RA_W + 1;

    cu_mc_state_t    state_r, state_nx;
    logic [RA_W-1:0] cnt_r, cnt_nx;

    logic [6:0]      opc;
    logic [RA_W-1:0] dr, sa, sb;
    logic [AW-1:0]   da_f, aa_f, ba_f, tmp_a;
    logic            cnt_more;
    cu_dec_t         dec;

    assign opc      = 7'(ins_in[INS_W-1 -: OPC_W]);
    assign dr       = ins_in[3*RA_W-1 -: RA_W];
    assign sa       = ins_in[2*RA_W-1 -: RA_W];
    assign sb       = ins_in[RA_W-1:0];
    assign da_f     = {1'b0, dr};
    assign aa_f     = {1'b0, sa};
    assign ba_f     = {1'b0, sb};
    assign tmp_a    = {1'b1, {RA_W{1'b0}}};
    assign cnt_more = (cnt_r > RA_W'(1));

    cu_dec u_dec (
        .opc   (opc),
        .dec_c (dec)
    );

    // State and shift-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Next-state and shift-count update.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            RST: state_nx = INF;
            INF: if (rdy_in) state_nx = EX0;
            EX0: begin
                if ((dec.mem || dec.io) && !rdy_in) begin
                    state_nx = EX0;
                end else if (dec.halt) begin
                    state_nx = HLT;
                end else if (dec.shiftm && (sb != '0)) begin
                    state_nx = EXS;
                    cnt_nx   = sb;
                end else begin
                    state_nx = INF;
                end
            end
            EXS: begin
                if (cnt_more) cnt_nx = cnt_r - RA_W'(1);
                else          state_nx = INF;
            end
            HLT: if (run_in) state_nx = INF;
            default: state_nx = RST;
        endcase
    end

    // Microoperation outputs for the current state.
    always_comb begin
        il_out      = 1'b0;
        ps_out      = PS_HOLD;
        rw_out      = 1'b0;
        rs_out      = '0;
        mm_out      = 1'b0;
        md_out      = MD_ALU;
        mb_out      = 1'b0;
        fs_out      = 4'b0000;
        wen_out     = 1'b1;
        iom_out     = 1'b0;
        req_out     = 1'b0;
        halted_out  = 1'b0;
        illegal_out = 1'b0;
        case (state_r)
            INF: begin
                mm_out  = 1'b1;
                req_out = 1'b1;
                il_out  = rdy_in;
            end
            EX0: begin
                if (dec.alu) begin
                    rs_out = {da_f, aa_f, ba_f};
                    fs_out = opc[3:0];
                    rw_out = 1'b1;
                    ps_out = PS_INC;
                    mb_out = dec.imm;
                end else if (dec.mem || dec.io) begin
                    rs_out  = {da_f, aa_f, ba_f};
                    req_out = 1'b1;
                    iom_out = dec.io;
                    if (rdy_in) begin
                        ps_out = PS_INC;
                        if (dec.load) begin
                            rw_out = 1'b1;
                            md_out = dec.io ? MD_IO : MD_MEM;
                        end else begin
                            wen_out = 1'b0;
                        end
                    end
                end else if (dec.br) begin
                    rs_out = {da_f, aa_f, ba_f};
                    case (opc)
                        OP_BRZ:  ps_out = z_in ? PS_BR : PS_INC;
                        OP_BRN:  ps_out = n_in ? PS_BR : PS_INC;
                        default: ps_out = PS_JMP;
                    endcase
                end else if (dec.shiftm) begin
                    // Zero count is a plain move; otherwise stage SA into the temp.
                    rw_out = 1'b1;
                    if (sb == '0) begin
                        rs_out = {da_f, aa_f, ba_f};
                        ps_out = PS_INC;
                    end else begin
                        rs_out = {tmp_a, aa_f, ba_f};
                    end
                end else if (dec.halt) begin
                    ps_out = PS_HOLD;
                end else begin
                    ps_out      = PS_INC;
                    illegal_out = dec.illegal;
                end
            end
            EXS: begin
                rs_out = {cnt_more ? tmp_a : da_f, {AW{1'b0}}, tmp_a};
                fs_out = opc[3:0];
                rw_out = 1'b1;
                ps_out = cnt_more ? PS_HOLD : PS_INC;
            end
            HLT: begin
                halted_out = 1'b1;
                ps_out     = run_in ? PS_INC : PS_HOLD;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_mc.sv
// Bench for cu_mc: reset, table of single-cycle instructions, hand-written
// multi-cycle sequences and a randomized instruction stream against a model.
module tb_cu_mc;
    import mycpu_pkg::*;

    localparam int unsigned RA_W  = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned INS_W = 16;
    localparam int unsigned RS_W  = 12;

    typedef struct packed {
        logic        il;
        logic [1:0]  ps;
        logic        rw;
        logic [11:0] rs;
        logic        mm;
        logic [1:0]  md;
        logic        mb;
        logic [3:0]  fs;
        logic        wen;
        logic        iom;
        logic        req;
        logic        halted;
        logic        illegal;
    } outs_t;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        logic        n;
        logic [1:0]  ps;
        logic        rw;
        logic [11:0] rs;
        logic [3:0]  fs;
        logic        mb;
        logic        ill;
    } vec_t;

    localparam logic [6:0] OPS [0:24] = '{
        OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT,
        OP_MOVB, OP_SHR, OP_SHL, OP_SRM, OP_SLM, OP_LD, OP_IOR, OP_ST, OP_IOW,
        OP_LDI, OP_ADI, OP_BRZ, OP_BRN, OP_JMP, OP_HAL, OP_XXL};

    logic             clk = 1'b0;
    logic             rst;
    logic [INS_W-1:0] ins_in;
    logic             z_in, n_in, rdy_in, run_in;
    logic             il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
    logic             req_out, halted_out, illegal_out;
    logic [1:0]       ps_out, md_out;
    logic [RS_W-1:0]  rs_out;
    logic [3:0]       fs_out;

    outs_t act;
    outs_t exp_q [$];
    int    n_vec = 0;
    int    n_err = 0;
    vec_t  tbl [12];

    always #5 clk = ~clk;

    cu_mc #(.RA_W(RA_W), .OPC_W(OPC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ins_in      (ins_in),
        .z_in        (z_in),
        .n_in        (n_in),
        .rdy_in      (rdy_in),
        .run_in      (run_in),
        .il_out      (il_out),
        .ps_out      (ps_out),
        .rw_out      (rw_out),
        .rs_out      (rs_out),
        .mm_out      (mm_out),
        .md_out      (md_out),
        .mb_out      (mb_out),
        .fs_out      (fs_out),
        .wen_out     (wen_out),
        .iom_out     (iom_out),
        .req_out     (req_out),
        .halted_out  (halted_out),
        .illegal_out (illegal_out)
    );

    always_comb act = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
                       fs_out, wen_out, iom_out, req_out, halted_out, illegal_out};

    function automatic outs_t dflt();
        outs_t o = '0;
        o.wen = 1'b1;
        return o;
    endfunction

    function automatic outs_t inf_o(input logic rdy);
        outs_t o = dflt();
        o.mm  = 1'b1;
        o.req = 1'b1;
        o.il  = rdy;
        return o;
    endfunction

    task automatic chk_now(input string nm, input outs_t e);
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    // One clock cycle: sample at the falling edge, then step past the rising edge.
    task automatic chk(input string nm, input outs_t e);
        @(negedge clk);
        chk_now(nm, e);
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs of one instruction's execute phase.
    // w is the number of wait cycles (memory/IO) or halt cycles before resume.
    function automatic void build(input logic [15:0] ins, input logic z,
                                  input logic n, input int w);
        logic [6:0]  op;
        logic [3:0]  da, aa, ba;
        logic [11:0] rsf;
        int          k;
        outs_t       o;
        op  = ins[15:9];
        da  = {1'b0, ins[8:6]};
        aa  = {1'b0, ins[5:3]};
        ba  = {1'b0, ins[2:0]};
        rsf = {da, aa, ba};
        k   = int'(ins[2:0]);
        o   = dflt();
        exp_q.delete();
        if (op inside {OP_MOVA, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_AND, OP_OR, OP_XOR,
                       OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_LDI, OP_ADI}) begin
            o.rs = rsf; o.fs = op[3:0]; o.rw = 1'b1; o.ps = 2'b01;
            o.mb = (op == OP_LDI) || (op == OP_ADI);
            exp_q.push_back(o);
        end else if (op inside {OP_LD, OP_ST, OP_IOR, OP_IOW}) begin
            o.rs = rsf; o.req = 1'b1; o.iom = (op == OP_IOR) || (op == OP_IOW);
            repeat (w) exp_q.push_back(o);
            o.ps = 2'b01;
            if (op == OP_LD || op == OP_IOR) begin
                o.rw = 1'b1;
                o.md = (op == OP_IOR) ? 2'b10 : 2'b01;
            end else begin
                o.wen = 1'b0;
            end
            exp_q.push_back(o);
        end else if (op inside {OP_BRZ, OP_BRN, OP_JMP}) begin
            o.rs = rsf;
            if (op == OP_JMP)      o.ps = 2'b11;
            else if (op == OP_BRZ) o.ps = z ? 2'b10 : 2'b01;
            else                   o.ps = n ? 2'b10 : 2'b01;
            exp_q.push_back(o);
        end else if (op == OP_SRM || op == OP_SLM) begin
            o.rw = 1'b1;
            if (k == 0) begin
                o.rs = rsf; o.ps = 2'b01;
                exp_q.push_back(o);
            end else begin
                o.rs = {4'h8, aa, ba};
                exp_q.push_back(o);
                for (int i = k; i >= 1; i--) begin
                    o = dflt();
                    o.rw = 1'b1; o.fs = op[3:0];
                    o.rs = {(i == 1) ? da : 4'h8, 4'h0, 4'h8};
                    o.ps = (i == 1) ? 2'b01 : 2'b00;
                    exp_q.push_back(o);
                end
            end
        end else if (op == OP_HAL) begin
            exp_q.push_back(o);
            o.halted = 1'b1;
            repeat (w) exp_q.push_back(o);
            o.ps = 2'b01;
            exp_q.push_back(o);
        end else begin
            o.ps = 2'b01;
            o.illegal = (op != OP_XXL);
            exp_q.push_back(o);
        end
    endfunction

    // Fetch (with fw not-ready cycles) and execute one instruction against the model.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int w,
                             input logic z, input logic n);
        logic [6:0] op;
        bit         is_mem, is_hal;
        op     = ins[15:9];
        is_mem = op inside {OP_LD, OP_ST, OP_IOR, OP_IOW};
        is_hal = (op == OP_HAL);
        ins_in = ins; z_in = z; n_in = n;
        for (int i = 0; i < fw; i++) begin
            rdy_in = 1'b0; run_in = 1'($urandom);
            chk("fetch_wait", inf_o(1'b0));
        end
        rdy_in = 1'b1; run_in = 1'($urandom);
        chk("fetch", inf_o(1'b1));
        build(ins, z, n, w);
        for (int c = 0; c < exp_q.size(); c++) begin
            rdy_in = is_mem ? (c == w) : 1'($urandom);
            if (!is_hal || c == 0) run_in = 1'($urandom);
            else                   run_in = (c == w + 1);
            chk($sformatf("exec op=%b cyc=%0d", op, c), exp_q[c]);
        end
    endtask

    initial begin
        outs_t       o;
        logic [15:0] ins;
        logic [6:0]  op;

        tbl = '{
            '{{OP_ADD, 3'd3, 3'd1, 3'd2},     1'b0, 1'b0, 2'b01, 1'b1, 12'h312, 4'h2, 1'b0, 1'b0},
            '{{OP_SUB, 3'd0, 3'd7, 3'd1},     1'b0, 1'b0, 2'b01, 1'b1, 12'h071, 4'h5, 1'b0, 1'b0},
            '{{OP_LDI, 3'd1, 3'd0, 3'd5},     1'b0, 1'b0, 2'b01, 1'b1, 12'h105, 4'hC, 1'b1, 1'b0},
            '{{OP_ADI, 3'd7, 3'd6, 3'd7},     1'b0, 1'b0, 2'b01, 1'b1, 12'h767, 4'h2, 1'b1, 1'b0},
            '{{OP_BRZ, 3'd0, 3'd2, 3'd0},     1'b1, 1'b0, 2'b10, 1'b0, 12'h020, 4'h0, 1'b0, 1'b0},
            '{{OP_BRZ, 3'd0, 3'd2, 3'd0},     1'b0, 1'b1, 2'b01, 1'b0, 12'h020, 4'h0, 1'b0, 1'b0},
            '{{OP_BRN, 3'd0, 3'd3, 3'd0},     1'b0, 1'b1, 2'b10, 1'b0, 12'h030, 4'h0, 1'b0, 1'b0},
            '{{OP_BRN, 3'd0, 3'd3, 3'd0},     1'b1, 1'b0, 2'b01, 1'b0, 12'h030, 4'h0, 1'b0, 1'b0},
            '{{OP_JMP, 3'd0, 3'd4, 3'd0},     1'b0, 1'b0, 2'b11, 1'b0, 12'h040, 4'h0, 1'b0, 1'b0},
            '{{OP_XXL, 3'd1, 3'd2, 3'd3},     1'b0, 1'b0, 2'b01, 1'b0, 12'h000, 4'h0, 1'b0, 1'b0},
            '{{7'b1010101, 3'd1, 3'd2, 3'd3}, 1'b0, 1'b0, 2'b01, 1'b0, 12'h000, 4'h0, 1'b0, 1'b1},
            '{{OP_SLM, 3'd2, 3'd5, 3'd0},     1'b0, 1'b0, 2'b01, 1'b1, 12'h250, 4'h0, 1'b0, 1'b0}
        };

        rst = 1'b1; rdy_in = 1'b1; run_in = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0;
        #2;
        chk("reset0", dflt());
        chk("reset1", dflt());
        rst = 1'b0;
        chk("rst_state", dflt());

        // Single-cycle instructions from the table.
        foreach (tbl[i]) begin
            ins_in = tbl[i].ins; z_in = tbl[i].z; n_in = tbl[i].n; rdy_in = 1'b1;
            chk("tbl_fetch", inf_o(1'b1));
            o = dflt();
            o.ps = tbl[i].ps; o.rw = tbl[i].rw; o.rs = tbl[i].rs;
            o.fs = tbl[i].fs; o.mb = tbl[i].mb; o.illegal = tbl[i].ill;
            chk($sformatf("tbl%0d", i), o);
        end

        // SLM R4,R1,#3: stage into temp, three shift steps, PC advances once.
        ins_in = {OP_SLM, 3'd4, 3'd1, 3'd3}; rdy_in = 1'b1;
        chk("slm_fetch", inf_o(1'b1));
        o = dflt(); o.rs = 12'h813; o.rw = 1'b1;
        chk("slm_ex0", o);
        o = dflt(); o.rs = 12'h808; o.fs = 4'hE; o.rw = 1'b1;
        chk("slm_exs1", o);
        chk("slm_exs2", o);
        o.rs = 12'h408; o.ps = 2'b01;
        chk("slm_exs3", o);

        // LD R5,(R2) with three wait states; HAL held five cycles then resumed.
        run_instr({OP_LD, 3'd5, 3'd2, 3'd0}, 0, 3, 1'b0, 1'b0);
        run_instr({OP_HAL, 3'd0, 3'd0, 3'd0}, 1, 5, 1'b0, 1'b0);

        // Reset asserted in the middle of a shift loop kills the write at once.
        ins_in = {OP_SLM, 3'd4, 3'd1, 3'd3}; rdy_in = 1'b1;
        chk("abort_fetch", inf_o(1'b1));
        o = dflt(); o.rs = 12'h813; o.rw = 1'b1;
        chk("abort_ex0", o);
        o = dflt(); o.rs = 12'h808; o.fs = 4'hE; o.rw = 1'b1;
        chk("abort_exs1", o);
        rst = 1'b1;
        #1;
        chk_now("abort_immediate", dflt());
        chk("abort_hold", dflt());
        rst = 1'b0;
        chk("abort_rst_state", dflt());

        // Randomized instruction stream.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else                           op = OPS[$urandom_range(0, 24)];
            ins = {op, 9'($urandom)};
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
